// File: rtl/demux_symbol_sched.sv
// demux_symbol_sched
//   Symbol scheduler for the 1:2 nibble demultiplexer in the Zigbee transmit
//   path. Bytes arrive over a valid/ready handshake. Each byte is split into
//   two 4-bit symbols, and each symbol is held for SYM_PERIOD clocks on the
//   demux data input. The demux select is driven so that the first nibble
//   lands on lane 0 and the second nibble lands on lane 1.
//
// Handshake: a byte transfers on a rising edge where inByteValid and
//   outByteReady are both high. inByte is sampled only on that edge.
//   outByteReady is combinational and never depends on inByteValid. It is
//   high when the block is idle, or in the last cycle of the second symbol,
//   provided the stream is enabled and reset is not asserted.
//
// Parameters
//   SYM_PERIOD  clocks each symbol is held (1..255)
//   LSB_FIRST   1: nibble [3:0] goes first, 0: nibble [7:4] goes first
//
// Ports
//   inClk          system clock, rising edge
//   inResetN       synchronous, active-low reset
//   inEnable       stream enable; gates byte acceptance only
//   inByte         byte to serialise
//   inByteValid    inByte is valid
//   outByteReady   byte accepted this cycle if valid
//   outSymbol      current symbol (demux data input)
//   outSel         demux select; 0 = first-nibble lane, 1 = second-nibble lane
//   outLaneValid   one-cycle strobe at the start of each symbol, per lane
//   outBusy        high whenever the FSM is not idle
//   outUnderrun    one-cycle pulse when the stream starves while enabled
//   dbg_state      FSM state (0 idle, 1 low/first symbol, 2 high/second symbol)
module demux_symbol_sched #(
   parameter int SYM_PERIOD = 16,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic       inClk,
   input  logic       inResetN,
   input  logic       inEnable,
   input  logic [7:0] inByte,
   input  logic       inByteValid,
   output logic       outByteReady,
   output logic [3:0] outSymbol,
   output logic       outSel,
   output logic [1:0] outLaneValid,
   output logic       outBusy,
   output logic       outUnderrun,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } state_t;

   // At least one counter bit, so that SYM_PERIOD = 1 still elaborates.
   localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SYM_PERIOD - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [7:0]    byte_reg;
   logic          load_byte;
   logic          at_last;
   logic          xfer;
   logic [1:0]    lane_valid_nxt;
   logic          underrun_nxt;
   logic [1:0]    lane_valid_q;
   logic          underrun_q;
   logic [3:0]    first_nib;
   logic [3:0]    second_nib;

   assign first_nib  = LSB_FIRST ? byte_reg[3:0] : byte_reg[7:4];
   assign second_nib = LSB_FIRST ? byte_reg[7:4] : byte_reg[3:0];

   // Next-state logic. The lane strobes and the underrun pulse are computed
   // here and registered, so each one appears on the first cycle of the new
   // symbol, or on the cycle after the last HIGH cycle.
   always_comb begin
      at_last        = (cnt == CNT_LAST);
      // Reset is included so that ready reads low while reset is held.
      outByteReady   = inResetN && inEnable &&
                       ((state == S_IDLE) || ((state == S_HIGH) && at_last));
      xfer           = inByteValid && outByteReady;
      state_nxt      = state;
      cnt_nxt        = cnt;
      load_byte      = 1'b0;
      lane_valid_nxt = 2'b00;
      underrun_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (xfer) begin
               state_nxt      = S_LOW;
               cnt_nxt        = '0;
               load_byte      = 1'b1;
               lane_valid_nxt = 2'b01;
            end
         end
         S_LOW: begin
            if (at_last) begin
               state_nxt      = S_HIGH;
               cnt_nxt        = '0;
               lane_valid_nxt = 2'b10;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_HIGH: begin
            if (at_last) begin
               cnt_nxt = '0;
               if (xfer) begin
                  // Back-to-back byte: go straight into its first symbol.
                  state_nxt      = S_LOW;
                  load_byte      = 1'b1;
                  lane_valid_nxt = 2'b01;
               end else begin
                  // With enable low this is a normal end of stream.
                  state_nxt    = S_IDLE;
                  underrun_nxt = inEnable;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge inClk) begin
      if (!inResetN) begin
         state        <= S_IDLE;
         cnt          <= '0;
         byte_reg     <= 8'h00;
         lane_valid_q <= 2'b00;
         underrun_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         lane_valid_q <= lane_valid_nxt;
         underrun_q   <= underrun_nxt;
         if (load_byte) begin
            byte_reg <= inByte;
         end
      end
   end

   always_comb begin
      outSymbol = 4'h0;
      case (state)
         S_LOW:   outSymbol = first_nib;
         S_HIGH:  outSymbol = second_nib;
         default: outSymbol = 4'h0;
      endcase
   end

   assign outSel       = (state == S_HIGH);
   assign outBusy      = (state != S_IDLE);
   assign outLaneValid = lane_valid_q;
   assign outUnderrun  = underrun_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_demux_symbol_sched.sv
// Bench for demux_symbol_sched. Two instances share the same stimulus: one
// sends the low nibble first and the other sends the high nibble first.
// Both use SYM_PERIOD = 4.
module tb_demux_symbol_sched;

   localparam int SP = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en;
   logic [7:0] byte_in;
   logic       valid;

   logic       rdy_l, sel_l, busy_l, und_l;
   logic [3:0] sym_l;
   logic [1:0] lv_l, st_l;
   logic       rdy_m, sel_m, busy_m, und_m;
   logic [3:0] sym_m;
   logic [1:0] lv_m, st_m;

   demux_symbol_sched #(.SYM_PERIOD(SP), .LSB_FIRST(1'b1)) dut_lsb (
      .inClk(clk), .inResetN(rst_n), .inEnable(en), .inByte(byte_in),
      .inByteValid(valid), .outByteReady(rdy_l), .outSymbol(sym_l),
      .outSel(sel_l), .outLaneValid(lv_l), .outBusy(busy_l),
      .outUnderrun(und_l), .dbg_state(st_l)
   );

   demux_symbol_sched #(.SYM_PERIOD(SP), .LSB_FIRST(1'b0)) dut_msb (
      .inClk(clk), .inResetN(rst_n), .inEnable(en), .inByte(byte_in),
      .inByteValid(valid), .outByteReady(rdy_m), .outSymbol(sym_m),
      .outSel(sel_m), .outLaneValid(lv_m), .outBusy(busy_m),
      .outUnderrun(und_m), .dbg_state(st_m)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [4:0] exp_l[$];   // {lane, symbol} in strobe order
   logic [4:0] exp_m[$];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // On every lane strobe, pop one expected {lane, symbol} entry.
   always @(negedge clk) begin
      if (lv_l !== 2'b00) begin
         chk("sb_l_onehot", 8'($countones(lv_l)), 8'd1);
         chk("sb_l_sel", 8'(sel_l), 8'(lv_l[1]));
         chk("sb_l_nonempty", 8'(exp_l.size() != 0), 8'd1);
         if (exp_l.size() != 0) chk("sb_l_sym", 8'({lv_l[1], sym_l}), 8'(exp_l.pop_front()));
      end
      if (lv_m !== 2'b00) begin
         chk("sb_m_onehot", 8'($countones(lv_m)), 8'd1);
         chk("sb_m_sel", 8'(sel_m), 8'(lv_m[1]));
         chk("sb_m_nonempty", 8'(exp_m.size() != 0), 8'd1);
         if (exp_m.size() != 0) chk("sb_m_sym", 8'({lv_m[1], sym_m}), 8'(exp_m.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] b);
      byte_in = b;
      valid   = 1'b1;
      exp_l.push_back({1'b0, b[3:0]});
      exp_l.push_back({1'b1, b[7:4]});
      exp_m.push_back({1'b0, b[7:4]});
      exp_m.push_back({1'b1, b[3:0]});
   endtask

   // Checks one cycle at the negative edge, then returns 1 time unit after
   // the next rising edge, ready for the next input change.
   task automatic cyc(input string tag, input logic [3:0] e_sym_l, input logic [3:0] e_sym_m,
                      input logic e_sel, input logic [1:0] e_lv, input logic e_rdy,
                      input logic e_busy, input logic e_und);
      @(negedge clk);
      chk({tag, "_sym_l"},  8'(sym_l),  8'(e_sym_l));
      chk({tag, "_sym_m"},  8'(sym_m),  8'(e_sym_m));
      chk({tag, "_sel_l"},  8'(sel_l),  8'(e_sel));
      chk({tag, "_sel_m"},  8'(sel_m),  8'(e_sel));
      chk({tag, "_lv_l"},   8'(lv_l),   8'(e_lv));
      chk({tag, "_lv_m"},   8'(lv_m),   8'(e_lv));
      chk({tag, "_rdy_l"},  8'(rdy_l),  8'(e_rdy));
      chk({tag, "_rdy_m"},  8'(rdy_m),  8'(e_rdy));
      chk({tag, "_busy_l"}, 8'(busy_l), 8'(e_busy));
      chk({tag, "_busy_m"}, 8'(busy_m), 8'(e_busy));
      chk({tag, "_und_l"},  8'(und_l),  8'(e_und));
      chk({tag, "_und_m"},  8'(und_m),  8'(e_und));
      @(posedge clk);
      #1;
   endtask

   // Cycles 1..ncyc after byte b was accepted on cycle 0. If drop_after is
   // nonzero, enable is lowered from cycle drop_after+1 onwards.
   task automatic play(input logic [7:0] b, input logic rdy_last, input int drop_after,
                       input int ncyc);
      for (int c = 1; c <= ncyc; c++) begin
         logic [3:0] sl;
         logic [3:0] sm;
         logic [1:0] lv;
         sl = (c <= SP) ? b[3:0] : b[7:4];
         sm = (c <= SP) ? b[7:4] : b[3:0];
         lv = (c == 1) ? 2'b01 : ((c == SP + 1) ? 2'b10 : 2'b00);
         cyc($sformatf("b%02h_c%0d", b, c), sl, sm, 1'(c > SP), lv,
             (c == 2 * SP) ? rdy_last : 1'b0, 1'b1, 1'b0);
         if (c == drop_after) en = 1'b0;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      valid   = 1'b1;
      byte_in = 8'hFF;

      // Reset held for 3 cycles with valid high.
      for (int i = 0; i < 3; i++) cyc("rst", 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("rst_state", 8'(st_l), 8'd0);
      rst_n = 1'b1;
      valid = 1'b0;
      cyc("idle0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

      // Single byte 0xA5, enable stays high, so an underrun follows.
      send(8'hA5);
      cyc("a5_c0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      valid = 1'b0;
      play(8'hA5, 1'b1, 0, 2 * SP);
      cyc("a5_c9", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
      cyc("a5_c10", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

      // Back-to-back 0x3C then 0x7E with valid held.
      send(8'h3C);
      cyc("3c_c0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      send(8'h7E);
      play(8'h3C, 1'b1, 0, 2 * SP);
      valid = 1'b0;
      play(8'h7E, 1'b1, 0, 2 * SP);
      cyc("7e_end", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

      // 0x12 with enable dropped on cycle 2: both symbols, then quiet idle.
      send(8'h12);
      cyc("12_c0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      valid = 1'b0;
      play(8'h12, 1'b0, 1, 2 * SP);
      byte_in = 8'hFF;
      valid   = 1'b1;
      cyc("12_c9", 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      cyc("12_c10", 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("12_state", 8'(st_l), 8'd0);
      valid = 1'b0;
      en    = 1'b1;
      cyc("12_c11", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

      // 0x5A with reset on cycle 6, in the middle of the second symbol.
      send(8'h5A);
      cyc("5a_c0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      valid = 1'b0;
      play(8'h5A, 1'b0, 0, SP + 1);
      rst_n = 1'b0;
      cyc("5a_c6", 4'h5, 4'hA, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      cyc("5a_c7", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      send(8'hC3);
      cyc("c3_c0", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      valid = 1'b0;
      play(8'hC3, 1'b1, 0, 2 * SP);
      cyc("c3_end", 4'h0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

      // Random bytes with random gaps. Symbols are checked by the scoreboard.
      for (int i = 0; i < 8; i++) begin
         int k;
         send(8'($urandom_range(0, 255)));
         k = 0;
         @(negedge clk);
         while (!rdy_l && k < 40) begin
            @(negedge clk);
            k++;
         end
         chk("rnd_accept", 8'(rdy_l), 8'd1);
         @(posedge clk);
         #1;
         valid = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (2 * SP + 4) begin
         @(posedge clk);
         #1;
      end
      chk("drain_l", 8'(exp_l.size()), 8'd0);
      chk("drain_m", 8'(exp_m.size()), 8'd0);
      chk("drain_busy", 8'(busy_l), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
